// File: rtl/riscv_mc_datapath.sv
// Multicycle RV32I/RV32E datapath: phase sequencer, register file, immediate unit, ALU and
// inter-phase registers behind one shared valid/ready memory port; controls come from outside.
module riscv_mc_datapath #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regWrite,
  input  logic            memAccess,
  input  logic            memWrite,
  input  logic            PCsrc,
  input  logic            Jsrc,
  input  logic            ALUsrcB,
  input  logic [1:0]      ALUsrcA,
  input  logic [3:0]      ALUcontrol,
  input  logic [2:0]      immSrc,
  input  logic [1:0]      resultSrc,
  input  logic            memReady,
  input  logic [XLEN-1:0] memRdata,
  output logic [31:0]     instr,
  output logic            zero,
  output logic            negative,
  output logic            overflow,
  output logic            carry,
  output logic            memReq,
  output logic            memWe,
  output logic [XLEN-1:0] memAdr,
  output logic [XLEN-1:0] memWdata,
  output logic [XLEN-1:0] PC,
  output logic            retire
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(XLEN);
  localparam int M  = XLEN - 1;

  typedef enum logic [2:0] {S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q, oldpc_q, a_q, b_q, imm_q, aluout_q, ldata_q;
  logic [31:0]     ir_q;
  logic            memreq_q, memwe_q;
  logic [XLEN-1:0] rf_q [NREGS];

  logic [RW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_y, target, wb_val, pc4;
  logic [31:0]     imm32;
  logic [XLEN:0]   sum, dif;
  logic [SW-1:0]   shamt;

  assign rs1 = ir_q[15 +: RW];
  assign rs2 = ir_q[20 +: RW];
  assign rd  = ir_q[7 +: RW];
  assign rd1 = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rd2 = (rs2 == '0) ? '0 : rf_q[rs2];

  always_comb begin
    imm32 = '0;
    case (immSrc)
      3'd0: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      3'd1: imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      3'd2: imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      3'd3: imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      3'd4: imm32 = {ir_q[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end
  assign imm_ext = XLEN'($signed(imm32));

  always_comb begin
    src_a = '0;
    if (ALUsrcA == 2'b00)      src_a = a_q;
    else if (ALUsrcA == 2'b01) src_a = oldpc_q;
    src_b = ALUsrcB ? imm_q : b_q;
  end

  // Subtract as a + ~b + 1 so the top bit is the no-borrow flag directly.
  assign sum   = {1'b0, src_a} + {1'b0, src_b};
  assign dif   = {1'b0, src_a} + {1'b0, ~src_b} + {{XLEN{1'b0}}, 1'b1};
  assign shamt = src_b[SW-1:0];

  always_comb begin
    alu_y    = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (ALUcontrol)
      4'd0: begin
        alu_y    = sum[M:0];
        carry    = sum[XLEN];
        overflow = (src_a[M] == src_b[M]) && (sum[M] != src_a[M]);
      end
      4'd1: begin
        alu_y    = dif[M:0];
        carry    = dif[XLEN];
        overflow = (src_a[M] != src_b[M]) && (dif[M] != src_a[M]);
      end
      4'd2:  alu_y = src_a & src_b;
      4'd3:  alu_y = src_a | src_b;
      4'd4:  alu_y = src_a ^ src_b;
      4'd5:  alu_y[0] = $signed(src_a) < $signed(src_b);
      4'd6:  alu_y[0] = src_a < src_b;
      4'd7:  alu_y = src_a << shamt;
      4'd8:  alu_y = src_a >> shamt;
      4'd9:  alu_y = $unsigned($signed(src_a) >>> shamt);
      4'd10: alu_y = src_b;
      default: alu_y = '0;
    endcase
  end
  assign zero     = (alu_y == '0);
  assign negative = alu_y[M];

  assign pc4    = oldpc_q + XLEN'(4);
  assign target = ((Jsrc ? a_q : oldpc_q) + imm_q) & ~(XLEN'(Jsrc));

  always_comb begin
    wb_val = '0;
    case (resultSrc)
      2'b00:   wb_val = aluout_q;
      2'b01:   wb_val = pc4;
      2'b10:   wb_val = ldata_q;
      default: wb_val = '0;
    endcase
  end

  // Retire depends on memReady in MEM, so it stays combinational off the registered state.
  assign retire = (state_q == S_WB) ||
                  (state_q == S_EXEC && !memAccess && !regWrite) ||
                  (state_q == S_MEM && memReady && !regWrite);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_START;
      pc_q     <= RESET_PC;
      oldpc_q  <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluout_q <= '0;
      ldata_q  <= '0;
      memreq_q <= 1'b0;
      memwe_q  <= 1'b0;
    end else begin
      case (state_q)
        S_START: begin
          state_q  <= S_FETCH;
          memreq_q <= 1'b1;
          memwe_q  <= 1'b0;
        end
        S_FETCH: if (memReady) begin
          ir_q     <= memRdata[31:0];
          oldpc_q  <= pc_q;
          memreq_q <= 1'b0;
          state_q  <= S_DECODE;
        end
        S_DECODE: begin
          a_q     <= rd1;
          b_q     <= rd2;
          imm_q   <= imm_ext;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          aluout_q <= alu_y;
          pc_q     <= PCsrc ? target : pc4;
          if (memAccess) begin
            state_q  <= S_MEM;
            memreq_q <= 1'b1;
            memwe_q  <= memWrite;
          end else if (regWrite) begin
            state_q <= S_WB;
          end else begin
            state_q  <= S_FETCH;
            memreq_q <= 1'b1;
            memwe_q  <= 1'b0;
          end
        end
        S_MEM: if (memReady) begin
          ldata_q  <= memRdata;
          memwe_q  <= 1'b0;
          state_q  <= regWrite ? S_WB : S_FETCH;
          memreq_q <= !regWrite;
        end
        S_WB: begin
          state_q  <= S_FETCH;
          memreq_q <= 1'b1;
          memwe_q  <= 1'b0;
        end
        default: state_q <= S_START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_WB && regWrite && rd != '0) rf_q[rd] <= wb_val;
  end

  assign instr    = ir_q;
  assign PC       = pc_q;
  assign memReq   = memreq_q;
  assign memWe    = memwe_q;
  assign memAdr   = (state_q == S_FETCH) ? pc_q : aluout_q;
  assign memWdata = b_q;
endmodule

// File: tb/tb_riscv_mc_datapath.sv
// Bench for riscv_mc_datapath: acts as decoder and memory, and checks every instruction
// against an ISA-level model (registers, PC, memory traffic, cycle count).
module tb_riscv_mc_datapath;
  localparam int K_R = 0, K_I = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4, K_JALR = 5,
                 K_BR = 6, K_LW = 7, K_SW = 8;

  typedef struct packed {
    logic regWrite, memAccess, memWrite, PCsrc, Jsrc, ALUsrcB;
    logic [1:0] ALUsrcA;
    logic [3:0] ALUcontrol;
    logic [2:0] immSrc;
    logic [1:0] resultSrc;
  } ctrl_t;

  typedef struct {
    int kind;
    int fn;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rst64 = 1'b1;
  logic memReady = 1'b0;
  logic [31:0] memRdata = '0;
  logic [31:0] instr, memAdr, memWdata, PC;
  logic zero, negative, overflow, carry, memReq, memWe, retire;
  ctrl_t c;

  logic memReady64;
  logic [63:0] memRdata64, memAdr64, memWdata64, PC64;
  logic [31:0] instr64;
  logic zero64, negative64, overflow64, carry64, memReq64, memWe64, retire64;
  ctrl_t c64;

  int n_vec = 0, n_err = 0;
  logic [31:0] xr [32];
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] pc_m;

  // ---------------- environment: decoder ----------------
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000: return alt ? 4'd1 : 4'd0;
      3'b001: return 4'd7;
      3'b010: return 4'd5;
      3'b011: return 4'd6;
      3'b100: return 4'd4;
      3'b101: return alt ? 4'd9 : 4'd8;
      3'b110: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic ctrl_t decode(input logic [31:0] ir, input logic z);
    ctrl_t d;
    logic [2:0] f3;
    d = '0;
    f3 = ir[14:12];
    case (ir[6:0])
      7'b0110011: begin d.regWrite = 1; d.ALUcontrol = alu_fn(f3, ir[30]); end
      7'b0010011: begin d.regWrite = 1; d.ALUsrcB = 1; d.ALUcontrol = alu_fn(f3, ir[30] && f3 == 3'b101); end
      7'b0110111: begin d.regWrite = 1; d.ALUsrcA = 2'b10; d.ALUsrcB = 1; d.immSrc = 3'd4; end
      7'b0010111: begin d.regWrite = 1; d.ALUsrcA = 2'b01; d.ALUsrcB = 1; d.immSrc = 3'd4; end
      7'b1101111: begin d.regWrite = 1; d.PCsrc = 1; d.immSrc = 3'd3; d.resultSrc = 2'b01; end
      7'b1100111: begin d.regWrite = 1; d.PCsrc = 1; d.Jsrc = 1; d.resultSrc = 2'b01; end
      7'b1100011: begin
        d.immSrc = 3'd2;
        case (f3)
          3'b000: begin d.ALUcontrol = 4'd1; d.PCsrc = z;  end
          3'b001: begin d.ALUcontrol = 4'd1; d.PCsrc = !z; end
          3'b100: begin d.ALUcontrol = 4'd5; d.PCsrc = !z; end
          3'b101: begin d.ALUcontrol = 4'd5; d.PCsrc = z;  end
          3'b110: begin d.ALUcontrol = 4'd6; d.PCsrc = !z; end
          default: begin d.ALUcontrol = 4'd6; d.PCsrc = z; end
        endcase
      end
      7'b0000011: begin d.regWrite = 1; d.memAccess = 1; d.ALUsrcB = 1; d.resultSrc = 2'b10; end
      7'b0100011: begin d.memAccess = 1; d.memWrite = 1; d.ALUsrcB = 1; d.immSrc = 3'd1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  // ---------------- instruction encoding ----------------
  function automatic logic [2:0] fn_f3(input int fn);
    case (fn)
      0, 1: return 3'd0;
      2: return 3'd1;
      3: return 3'd2;
      4: return 3'd3;
      5: return 3'd4;
      6, 7: return 3'd5;
      8: return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] br_f3(input int fn);
    case (fn)
      0: return 3'd0;
      1: return 3'd1;
      2: return 3'd4;
      3: return 3'd5;
      4: return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] enc(input ins_t d);
    logic [31:0] im;
    logic [6:0] f7;
    im = d.imm;
    f7 = (d.fn == 1 || d.fn == 7) ? 7'h20 : 7'h00;
    case (d.kind)
      K_R:     return {f7, d.rs2, d.rs1, fn_f3(d.fn), d.rd, 7'b0110011};
      K_I:     if (d.fn == 2 || d.fn == 6 || d.fn == 7)
                 return {f7, im[4:0], d.rs1, fn_f3(d.fn), d.rd, 7'b0010011};
               else return {im[11:0], d.rs1, fn_f3(d.fn), d.rd, 7'b0010011};
      K_LUI:   return {im[31:12], d.rd, 7'b0110111};
      K_AUIPC: return {im[31:12], d.rd, 7'b0010111};
      K_JAL:   return {im[20], im[10:1], im[11], im[19:12], d.rd, 7'b1101111};
      K_JALR:  return {im[11:0], d.rs1, 3'b000, d.rd, 7'b1100111};
      K_BR:    return {im[12], im[10:5], d.rs2, d.rs1, br_f3(d.fn), im[4:1], im[11], 7'b1100011};
      K_LW:    return {im[11:0], d.rs1, 3'b010, d.rd, 7'b0000011};
      default: return {im[11:5], d.rs2, d.rs1, 3'b010, im[4:0], 7'b0100011};
    endcase
  endfunction

  function automatic ins_t mk(input int kind, input int fn, input int rd, input int rs1,
                              input int rs2, input logic [31:0] imm);
    ins_t d;
    d.kind = kind; d.fn = fn; d.imm = imm;
    d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
    return d;
  endfunction

  // ---------------- reference model (ISA level) ----------------
  function automatic logic [31:0] dm_read(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : a * 32'h9E3779B1;
  endfunction

  function automatic logic [31:0] alu_ref(input int fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      0: return a + b;
      1: return a - b;
      2: return a << b[4:0];
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> b[4:0];
      7: return $unsigned($signed(a) >>> b[4:0]);
      8: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit br_taken(input int fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      0: return a == b;
      1: return a != b;
      2: return $signed(a) < $signed(b);
      3: return $signed(a) >= $signed(b);
      4: return a < b;
      default: return a >= b;
    endcase
  endfunction

  task automatic model(input ins_t d, output logic [31:0] npc, output bit wr, output logic [31:0] val,
                       output bit macc, output bit mwe, output logic [31:0] madr,
                       output logic [31:0] mwd, output int cyc, output bit cf, output bit vf);
    logic [31:0] a, b, pc4;
    logic [32:0] wide;
    a = xr[d.rs1]; b = xr[d.rs2]; pc4 = pc_m + 32'd4;
    npc = pc4; wr = 0; val = '0; macc = 0; mwe = 0; madr = '0; mwd = '0; cyc = 4; cf = 0; vf = 0;
    case (d.kind)
      K_R: begin
        wr = 1; val = alu_ref(d.fn, a, b);
        wide = {1'b0, a} + {1'b0, b};
        if (d.fn == 0) begin cf = wide[32]; vf = (a[31] == b[31]) && (val[31] != a[31]); end
        if (d.fn == 1) begin cf = (a >= b); vf = (a[31] != b[31]) && (val[31] != a[31]); end
      end
      K_I:     begin wr = 1; val = alu_ref(d.fn, a, d.imm); end
      K_LUI:   begin wr = 1; val = d.imm; end
      K_AUIPC: begin wr = 1; val = pc_m + d.imm; end
      K_JAL:   begin wr = 1; val = pc4; npc = pc_m + d.imm; end
      K_JALR:  begin wr = 1; val = pc4; npc = (a + d.imm) & ~32'd1; end
      K_BR:    begin cyc = 3; if (br_taken(d.fn, a, b)) npc = pc_m + d.imm; end
      K_LW:    begin cyc = 5; wr = 1; macc = 1; madr = d.imm; val = dm_read(d.imm); end
      default: begin macc = 1; mwe = 1; madr = d.imm; mwd = b; dmem[d.imm] = b; end
    endcase
    if (wr && d.rd != 0) xr[d.rd] = val;
  endtask

  // ---------------- DUTs ----------------
  always_comb c = decode(instr, zero);
  always_comb c64 = decode(instr64, zero64);

  // 64-bit instance runs a fixed two-instruction program from a zero-wait ROM.
  always_comb begin
    memReady64 = memReq64;
    case (memAdr64)
      64'd0:   memRdata64 = {32'h0, enc(mk(K_I, 0, 1, 0, 0, 32'd1))};
      64'd4:   memRdata64 = {32'h0, enc(mk(K_R, 1, 2, 0, 1, 32'd0))};
      default: memRdata64 = 64'h13;
    endcase
  end

  riscv_mc_datapath #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .regWrite(c.regWrite), .memAccess(c.memAccess), .memWrite(c.memWrite),
    .PCsrc(c.PCsrc), .Jsrc(c.Jsrc), .ALUsrcB(c.ALUsrcB), .ALUsrcA(c.ALUsrcA),
    .ALUcontrol(c.ALUcontrol), .immSrc(c.immSrc), .resultSrc(c.resultSrc),
    .memReady(memReady), .memRdata(memRdata), .instr(instr), .zero(zero), .negative(negative),
    .overflow(overflow), .carry(carry), .memReq(memReq), .memWe(memWe), .memAdr(memAdr),
    .memWdata(memWdata), .PC(PC), .retire(retire));

  riscv_mc_datapath #(.XLEN(64), .NREGS(32), .RESET_PC(64'h0)) u64 (
    .clk(clk), .rst(rst64), .regWrite(c64.regWrite), .memAccess(c64.memAccess),
    .memWrite(c64.memWrite), .PCsrc(c64.PCsrc), .Jsrc(c64.Jsrc), .ALUsrcB(c64.ALUsrcB),
    .ALUsrcA(c64.ALUsrcA), .ALUcontrol(c64.ALUcontrol), .immSrc(c64.immSrc),
    .resultSrc(c64.resultSrc), .memReady(memReady64), .memRdata(memRdata64), .instr(instr64),
    .zero(zero64), .negative(negative64), .overflow(overflow64), .carry(carry64),
    .memReq(memReq64), .memWe(memWe64), .memAdr(memAdr64), .memWdata(memWdata64), .PC(PC64),
    .retire(retire64));

  // ---------------- checking and drivers ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input ins_t d, input int wf, input int wm);
    logic [31:0] iw, e_pc, e_val, e_madr, e_wd;
    bit e_wr, e_mem, e_mwe, e_c, e_v, seen, got;
    int e_cyc, cyc, total, n;
    iw = enc(d);
    memReady = 0;
    n = 0;
    while (!memReq && n < 4) begin step(); n++; end
    chk("fetch_req", memReq, 1);
    chk("fetch_adr", memAdr, pc_m);
    chk("fetch_we", memWe, 0);
    cyc = 1;
    for (int w = 0; w < wf; w++) begin
      memReady = 0; step(); cyc++;
      chk("fetch_hold", memAdr, pc_m);
    end
    memReady = 1; memRdata = iw;
    step(); cyc++;
    memReady = 0; memRdata = $urandom();
    chk("ir", instr, iw);
    model(d, e_pc, e_wr, e_val, e_mem, e_mwe, e_madr, e_wd, e_cyc, e_c, e_v);
    n = wm; seen = 0; got = 0; total = 0;
    for (int k = 0; k < 24 && !got; k++) begin
      memReady = 0;
      if (memReq) begin
        seen = 1;
        chk("mem_adr", memAdr, e_madr);
        chk("mem_we", memWe, e_mwe);
        if (e_mwe) chk("mem_wdata", memWdata, e_wd);
        if (n > 0) n--;
        else begin memReady = 1; memRdata = dm_read(memAdr); end
      end
      #1;
      if (k == 1 && d.kind == K_R) begin
        chk("flag_z", zero, e_val == 0);
        chk("flag_n", negative, e_val[31]);
        chk("flag_v", overflow, e_v);
        if (d.fn <= 1) chk("flag_c", carry, e_c);
      end
      if (retire) begin got = 1; total = cyc; end
      else cyc++;
      step();
    end
    memReady = 0;
    chk("retired", got, 1);
    chk("mem_seen", seen, e_mem);
    chk("cycles", total, e_cyc + wf + (e_mem ? wm : 0));
    chk("pc", PC, e_pc);
    if (e_wr && d.rd != 0) chk("rd_val", dut.rf_q[d.rd], e_val);
    pc_m = e_pc;
  endtask

  function automatic ins_t gen_rand();
    ins_t d;
    logic [31:0] r;
    r = $urandom();
    d = mk($urandom_range(0, 8), 0, $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), {{20{r[11]}}, r[11:0]});
    case (d.kind)
      K_R: d.fn = $urandom_range(0, 9);
      K_I: begin
        d.fn = $urandom_range(0, 9);
        if (d.fn == 1) d.fn = 0;
        if (d.fn == 2 || d.fn == 6 || d.fn == 7) d.imm = $urandom_range(0, 31);
      end
      K_LUI, K_AUIPC: d.imm = r & 32'hFFFF_F000;
      K_JAL: d.imm = {{11{r[20]}}, r[20:1], 1'b0};
      K_BR: begin
        d.fn = $urandom_range(0, 5);
        d.imm = {{19{r[12]}}, r[12:1], 1'b0};
        if (r[30]) d.rs2 = d.rs1;
      end
      K_LW, K_SW: begin d.rs1 = 0; d.imm = 32'h100 + 32'($urandom_range(0, 15)) * 4; end
      default: ;
    endcase
    return d;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) xr[i] = '0;
    dmem[32'h100] = 32'hDEADBEEF;
    pc_m = 32'h0;

    // 64-bit instance: x1=1, then x2 = 0 - x1
    step();
    rst64 = 0;
    n = 0;
    while (!retire64 && n < 10) begin step(); n++; end
    chk("u64_first_retire", retire64, 1);
    chk("u64_fetch_we", memWe64, 0);
    step(); step(); step();
    chk("u64_sub_neg", negative64, 1);
    chk("u64_sub_carry", carry64, 0);
    chk("u64_sub_ovf", overflow64, 0);
    chk("u64_sub_zero", zero64, 0);
    step();
    chk("u64_retire", retire64, 1);
    chk("u64_wdata", memWdata64, 64'd1);
    step();
    chk("u64_x2", u64.rf_q[2], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("u64_pc", PC64, 64'd8);

    // Reset state, then abort a fetch with a mid-cycle reset
    chk("rst_req", memReq, 0);
    chk("rst_we", memWe, 0);
    chk("rst_retire", retire, 0);
    chk("rst_pc", PC, 0);
    chk("rst_ir", instr, 0);
    rst = 0;
    chk("start_noreq", memReq, 0);
    step();
    chk("first_req", memReq, 1);
    chk("first_adr", memAdr, 0);
    step(); step();
    chk("fetch_wait_req", memReq, 1);
    #2 rst = 1;
    #1 chk("rst_drops_req", memReq, 0);
    step();
    rst = 0;
    chk("rerst_pc", PC, 0);
    chk("rerst_ir", instr, 0);
    chk("rerst_start", memReq, 0);
    step();
    chk("rerst_fetch", memReq, 1);
    chk("rerst_adr", memAdr, 0);

    // Directed program
    run_instr(mk(K_I, 0, 1, 0, 0, 32'd5), 0, 0);
    run_instr(mk(K_R, 0, 2, 1, 1, 32'd0), 0, 0);
    chk("x2_is_10", dut.rf_q[2], 32'd10);
    chk("pc_is_8", PC, 32'd8);
    run_instr(mk(K_LW, 0, 3, 0, 0, 32'h100), 0, 3);
    chk("x3_load", dut.rf_q[3], 32'hDEADBEEF);
    run_instr(mk(K_I, 0, 4, 0, 0, 32'h201), 0, 0);
    run_instr(mk(K_JALR, 0, 5, 4, 0, 32'd0), 0, 0);
    chk("jalr_pc", PC, 32'h200);
    chk("jalr_link", dut.rf_q[5], 32'h14);
    run_instr(mk(K_JAL, 0, 0, 0, 0, -32'sd448), 1, 0);
    run_instr(mk(K_BR, 0, 0, 0, 0, -32'sd8), 0, 0);
    chk("br_taken_pc", PC, 32'h38);
    run_instr(mk(K_JAL, 0, 0, 0, 0, 32'd8), 0, 0);
    run_instr(mk(K_BR, 1, 0, 0, 0, -32'sd8), 2, 0);
    chk("br_not_taken_pc", PC, 32'h44);
    run_instr(mk(K_I, 0, 0, 0, 0, 32'd7), 0, 0);
    run_instr(mk(K_R, 0, 6, 0, 0, 32'd0), 0, 0);
    chk("x0_reads_0", dut.rf_q[6], 32'd0);

    // Give every register a defined value, then a random stream with random wait states
    for (int i = 1; i < 32; i++) begin
      logic [31:0] r;
      r = $urandom();
      run_instr(mk(K_I, 0, i, 0, 0, {{20{r[11]}}, r[11:0]}), $urandom_range(0, 1), 0);
    end
    for (int i = 0; i < 300; i++)
      run_instr(gen_rand(), $urandom_range(0, 2), $urandom_range(0, 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
